// File: rtl/alu_out_stage.sv
// Output stage after the Hack ALU bitwise gates. A 2-entry FIFO holds each
// word with its zr/ng flags, and a sticky OR-accumulator supports debug readout.
module alu_out_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zr,
  output logic             out_ng,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] acc_out,
  output logic             acc_zr,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] data_q [2];
  logic [WIDTH-1:0] data_d [2];
  logic             zr_q   [2];
  logic             zr_d   [2];
  logic             ng_q   [2];
  logic             ng_d   [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             push, pop;

  // in_ready ignores out_ready: no pass-through when full
  assign in_ready  = ~reset & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~reset;

  assign out_data = data_q[rd_ptr_q];
  assign out_zr   = zr_q[rd_ptr_q];
  assign out_ng   = ng_q[rd_ptr_q];
  assign acc_out  = acc_q;
  assign acc_zr   = ~|acc_q;
  assign count    = count_q;

  always_comb begin
    data_d   = data_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;

    if (push) begin
      data_d[wr_ptr_q] = in_data;
      zr_d[wr_ptr_q]   = ~|in_data;
      ng_d[wr_ptr_q]   = in_data[WIDTH-1];
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (acc_clr && push) begin
      acc_d = in_data;
    end else if (acc_clr) begin
      acc_d = '0;
    end else if (push) begin
      acc_d = acc_q | in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      zr_q[0]   <= 1'b1;
      zr_q[1]   <= 1'b1;
      ng_q[0]   <= 1'b0;
      ng_q[1]   <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      acc_q     <= '0;
    end else begin
      data_q    <= data_d;
      zr_q      <= zr_d;
      ng_q      <= ng_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_alu_out_stage.sv
// Scoreboard bench for alu_out_stage: directed scenarios followed by random
// traffic, checked against a queue-based model of the FIFO and accumulator.
module tb_alu_out_stage;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_zr;
  logic        out_ng;
  logic        out_valid;
  logic        out_ready;
  logic        acc_clr;
  logic [15:0] acc_out;
  logic        acc_zr;
  logic [1:0]  count;

  alu_out_stage #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_zr    (out_zr),
    .out_ng    (out_ng),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_clr   (acc_clr),
    .acc_out   (acc_out),
    .acc_zr    (acc_zr),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] sb_q[$];
  logic [15:0] m_acc = 16'h0;
  logic        m_fresh = 1'b1;
  logic        can_push = 1'b0;
  logic        started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model update on the active edge, using inputs driven in the previous cycle
  always @(posedge clk) begin
    started <= 1'b1;
    if (reset) begin
      sb_q.delete();
      m_acc   = 16'h0;
      m_fresh = 1'b1;
    end else begin
      if (acc_clr) m_acc = (in_valid && can_push) ? in_data : 16'h0;
      else if (in_valid && can_push) m_acc = m_acc | in_data;
      if (in_valid && can_push) begin
        sb_q.push_back(in_data);
        m_fresh = 1'b0;
      end
    end
  end

  // Monitor: compare outputs mid-cycle, pop the scoreboard on a modelled handshake
  always @(negedge clk) begin
    if (started) begin
      can_push = !reset && (sb_q.size() != 2);
      check("in_ready", in_ready, can_push);
      check("count", count, sb_q.size());
      check("out_valid", out_valid, sb_q.size() != 0);
      check("acc_out", acc_out, m_acc);
      check("acc_zr", acc_zr, m_acc == 16'h0);
      if (sb_q.size() != 0) begin
        check("out_data", out_data, sb_q[0]);
        check("out_zr", out_zr, sb_q[0] == 16'h0);
        check("out_ng", out_ng, sb_q[0][15]);
        if (out_ready && !reset) void'(sb_q.pop_front());
      end else if (m_fresh) begin
        check("idle_data", out_data, 16'h0);
        check("idle_zr", out_zr, 1'b1);
        check("idle_ng", out_ng, 1'b0);
      end
    end
  end

  task automatic cyc(input logic rst, input logic v, input logic [15:0] d,
                     input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    acc_clr   = clr;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0; acc_clr = 1'b0;
    cyc(1, 0, 16'h0, 0, 0);
    cyc(0, 0, 16'h0, 0, 0);
    cyc(0, 0, 16'h0, 0, 0);

    // single words and flags
    cyc(0, 1, 16'h8001, 1, 0);
    cyc(0, 1, 16'h0000, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);

    // backpressure: third word refused while full, then drained in order
    cyc(0, 1, 16'h1111, 0, 0);
    cyc(0, 1, 16'h2222, 0, 0);
    cyc(0, 1, 16'h3333, 0, 0);
    cyc(0, 1, 16'h3333, 0, 0);
    cyc(0, 1, 16'h3333, 1, 0);
    cyc(0, 1, 16'h3333, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);

    // simultaneous push/pop at count=1
    cyc(0, 1, 16'hAAAA, 0, 0);
    cyc(0, 1, 16'h5555, 1, 0);
    cyc(0, 0, 16'h0, 0, 0);
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);

    // accumulator
    cyc(0, 0, 16'h0, 1, 1);
    cyc(0, 1, 16'h000F, 1, 0);
    cyc(0, 1, 16'h00F0, 1, 0);
    cyc(0, 1, 16'h0100, 1, 1);
    cyc(0, 0, 16'h0, 1, 1);
    cyc(0, 0, 16'h0, 1, 0);

    // reset with a full FIFO and a handshake presented on both sides
    cyc(0, 1, 16'hFFFF, 0, 0);
    cyc(0, 1, 16'hF0F0, 0, 0);
    cyc(0, 0, 16'h0, 0, 0);
    cyc(1, 1, 16'h1234, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 7))
        0:       d = 16'h0000;
        1:       d = 16'h8000;
        default: d = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), d,
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    check("drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
